// File: rtl/kgp_pipe_pkg.sv
// rtl/kgp_pipe_pkg.sv - KGP node encoding and merge helpers for the pipelined prefix adder
package kgp_pipe_pkg;

    typedef logic [1:0] kgp_t;

    localparam kgp_t KGP_KILL = 2'b00;
    localparam kgp_t KGP_PROP = 2'b01;
    localparam kgp_t KGP_GEN  = 2'b11;

    // A resolved (kill/generate) upper group wins; a propagating one defers to the lower group.
    // Bit 1 of a resolved node is the group's carry out.
    function automatic kgp_t kgp_merge(input kgp_t hi, input kgp_t lo);
        return (hi == KGP_PROP) ? lo : hi;
    endfunction

    // Bit-level classification of one operand pair.
    function automatic kgp_t kgp_bit(input logic x, input logic y);
        if (x & y) begin
            return KGP_GEN;
        end else if (x ^ y) begin
            return KGP_PROP;
        end else begin
            return KGP_KILL;
        end
    endfunction

endpackage

// File: rtl/kgp_pipe_adder_cell.sv
// rtl/kgp_pipe_adder_cell.sv - kgp_cell: combinational merge of two KGP prefix nodes
module kgp_cell
    import kgp_pipe_pkg::*;
(
    input  kgp_t hi,
    input  kgp_t lo,
    output kgp_t grp
);

    assign grp = kgp_merge(hi, lo);

endmodule

// File: rtl/kgp_pipe_adder.sv
// rtl/kgp_pipe_adder.sv - pipelined Kogge-Stone KGP adder with stream handshake; KGP_PIPE_SUB_EN enables subtract
module kgp_pipe_adder
    import kgp_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LVL = $clog2(WIDTH);

    // One enable for the whole pipe: it only moves when the output slot is free or being drained.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operand conditioning: subtract is a + ~b + 1, so the inversion and forced carry live here.
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
`ifdef KGP_PIPE_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0_in = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c0_in      = cin;
`endif

    // Stage 0 registers (operands) and stage 1..LVL registers (prefix levels); index 0 of the
    // side-band arrays is stage 0.
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic             st_valid [0:LVL];
    logic             st_c0    [0:LVL];
    logic [TAG_W-1:0] st_tag   [0:LVL];
    logic [WIDTH-1:0] p_q      [1:LVL];
    kgp_t [WIDTH-1:0] lv_node  [1:LVL];

    // Bit-level KGP from the stage 0 operands; node 0 absorbs the carry in as its lower neighbour.
    kgp_t [WIDTH-1:0] bit_node;
    logic [WIDTH-1:0] p0;
    always_comb begin
        p0 = s0_a ^ s0_b;
        for (int i = 0; i < WIDTH; i++) begin
            bit_node[i] = kgp_bit(s0_a[i], s0_b[i]);
        end
        bit_node[0] = kgp_merge(kgp_bit(s0_a[0], s0_b[0]), st_c0[0] ? KGP_GEN : KGP_KILL);
    end

    // Level k reads the register of level k-1 (or the bit-level nodes for k = 1).
    kgp_t [WIDTH-1:0] lvl_src [0:LVL-1];
    logic [WIDTH-1:0] p_src   [0:LVL-1];
    kgp_t [WIDTH-1:0] lvl_out [1:LVL];

    assign lvl_src[0] = bit_node;
    assign p_src[0]   = p0;

    genvar gk, gi;
    generate
        for (gk = 1; gk < LVL; gk++) begin : g_src
            assign lvl_src[gk] = lv_node[gk];
            assign p_src[gk]   = p_q[gk];
        end

        for (gk = 1; gk <= LVL; gk++) begin : g_lvl
            localparam int D = 1 << (gk - 1);
            for (gi = 0; gi < WIDTH; gi++) begin : g_node
                if (gi >= D) begin : g_merge
                    kgp_cell u_cell (
                        .hi  (lvl_src[gk-1][gi]),
                        .lo  (lvl_src[gk-1][gi-D]),
                        .grp (lvl_out[gk][gi])
                    );
                end else begin : g_pass
                    assign lvl_out[gk][gi] = lvl_src[gk-1][gi];
                end
            end
        end
    endgenerate

    // Advance operand stage and every prefix level together; reset clears valid bits and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_a <= '0;
            s0_b <= '0;
            for (int k = 0; k <= LVL; k++) begin
                st_valid[k] <= 1'b0;
                st_c0[k]    <= 1'b0;
                st_tag[k]   <= '0;
            end
            for (int k = 1; k <= LVL; k++) begin
                p_q[k]     <= '0;
                lv_node[k] <= '0;
            end
        end else if (en) begin
            s0_a        <= a;
            s0_b        <= b_eff;
            st_valid[0] <= in_valid;
            st_c0[0]    <= c0_in;
            st_tag[0]   <= in_tag;
            for (int k = 1; k <= LVL; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_c0[k]    <= st_c0[k-1];
                st_tag[k]   <= st_tag[k-1];
                p_q[k]      <= p_src[k-1];
                lv_node[k]  <= lvl_out[k];
            end
        end
    end

    // After the last level every node i is resolved and its bit 1 is the carry into bit i+1.
    kgp_t [WIDTH-1:0] fin_node;
    logic [WIDTH-1:0] carry_in;
    logic [WIDTH-1:0] unused_fin_lsb;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    always_comb begin
        fin_node    = lv_node[LVL];
        carry_in    = '0;
        carry_in[0] = st_c0[LVL];
        for (int i = 1; i < WIDTH; i++) begin
            carry_in[i] = fin_node[i-1][1];
        end
        for (int i = 0; i < WIDTH; i++) begin
            unused_fin_lsb[i] = fin_node[i][0];
        end
        sum_d  = p_q[LVL] ^ carry_in;
        cout_d = fin_node[WIDTH-1][1];
        ovf_d  = carry_in[WIDTH-1] ^ cout_d;
    end

    // Output register: holds the result beat until downstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= st_valid[LVL];
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
            out_tag   <= st_tag[LVL];
        end
    end

endmodule

// File: tb/tb_kgp_pipe_adder.sv
// tb/tb_kgp_pipe_adder.sv - directed self-checking bench for kgp_pipe_adder at WIDTH=16
module tb_kgp_pipe_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kgp_pipe_adder #(.WIDTH(16), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push one beat with an idle pipe and count edges (accept edge included) until out_valid.
    task automatic send_one(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                            input logic vs, input logic [3:0] vt, output int lat);
        @(negedge clk);
        a = va; b = vb; cin = vc; sub = vs; in_tag = vt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input string nm, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic vs, input logic [3:0] vt,
                           input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        send_one(va, vb, vc, vs, vt, lat);
        check({nm, "_lat"}, lat, 6);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
        check({nm, "_ovf"}, ovf, eo);
        check({nm, "_tag"}, out_tag, vt);
    endtask

    function automatic logic [15:0] stream_a(input int i);
        return 16'hF000 + 16'(i) * 16'h0123;
    endfunction

    function automatic logic [15:0] stream_b(input int i);
        return 16'h1000 + 16'(i) * 16'h0011;
    endfunction

    initial begin
        int          idx;
        int          pop;
        int          cyc;
        int          seen;
        int          lat;
        logic        fire;
        logic        was_stall;
        logic [15:0] hold_sum;
        logic [3:0]  hold_tag;
        logic [16:0] ref_full;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);

        run_vec("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, 16'h0000, 1'b1, 1'b0);
        run_vec("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, 16'h8000, 1'b0, 1'b1);
        run_vec("cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 4'h3, 16'h5556, 1'b0, 1'b0);
        run_vec("novf",   16'h8000, 16'h8000, 1'b0, 1'b0, 4'h4, 16'h0000, 1'b1, 1'b1);
        run_vec("zero",   16'h0000, 16'h0000, 1'b1, 1'b0, 4'hF, 16'h0001, 1'b0, 1'b0);
`ifdef KGP_PIPE_SUB_EN
        run_vec("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 4'h5, 16'hFFFE, 1'b0, 1'b0);
        run_vec("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 4'h6, 16'h7FFF, 1'b1, 1'b1);
        run_vec("sub_cin", 16'h0009, 16'h0009, 1'b0, 1'b1, 4'h7, 16'h0000, 1'b1, 1'b0);
`else
        run_vec("sub_off", 16'h0005, 16'h0007, 1'b0, 1'b1, 4'h5, 16'h000C, 1'b0, 1'b0);
`endif

        // Ten back-to-back beats with a three-cycle output stall in the middle.
        idx = 0; pop = 0; cyc = 0; was_stall = 1'b0; hold_sum = '0; hold_tag = '0;
        sub = 1'b0; cin = 1'b0;
        while (pop < 10 && cyc < 80) begin
            @(negedge clk);
            out_ready = !(cyc >= 8 && cyc <= 10);
            in_valid  = (idx < 10);
            a         = stream_a(idx);
            b         = stream_b(idx);
            in_tag    = 4'(idx);
            #1;
            if (out_valid && out_ready) begin
                ref_full = {1'b0, stream_a(pop)} + {1'b0, stream_b(pop)};
                check("strm_tag", out_tag, pop);
                check("strm_sum", sum, ref_full[15:0]);
                check("strm_cout", cout, ref_full[16]);
                pop++;
                was_stall = 1'b0;
            end else if (out_valid) begin
                check("stall_in_ready", in_ready, 0);
                if (was_stall) begin
                    check("stall_sum", sum, hold_sum);
                    check("stall_tag", out_tag, hold_tag);
                end
                hold_sum  = sum;
                hold_tag  = out_tag;
                was_stall = 1'b1;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
            cyc++;
        end
        check("strm_count", pop, 10);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("strm_no_extra", out_valid, 0);

        // Four beats in flight, then a one-cycle reset must flush them all.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h0100 * 16'(i + 1);
            b = 16'h0001;
            in_tag = 4'(8 + i);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("rst_flush", seen, 0);
        check("rst_in_ready2", in_ready, 1);
        send_one(16'h00FF, 16'h0F01, 1'b0, 1'b0, 4'hA, lat);
        check("post_rst_lat", lat, 6);
        check("post_rst_sum", sum, 16'h1000);
        check("post_rst_tag", out_tag, 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
